clkdist_seq: RTL

CLKDIST_SEQ -- requirements
Module: clkdist_seq

---
 rtl/clkdist_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/clkdist_seq.sv
// Power-up sequencer for the clock distribution block.
// Walks OFF -> BIAS -> PWRUP -> SETTLE -> RUN, with a testbus (ATB) side state and a
// sticky FAULT state. Every output is a flop decoded from the state being entered.
module clkdist_seq (
    input  logic       clk,
    input  logic       rstb,
    input  logic       enable,
    input  logic       supply_ok,
    input  logic       iref_ok,
    input  logic [7:0] cfg_bias_wait,
    input  logic [7:0] cfg_settle,
    input  logic       atb_req,
    input  logic [1:0] atb_sel,
    output logic       pdb,
    output logic       clk_gate_en,
    output logic [1:0] atb_ena,
    output logic       atb_ack,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StBias   = 3'd1,
        StPwrup  = 3'd2,
        StSettle = 3'd3,
        StRun    = 3'd4,
        StAtb    = 3'd5,
        StFault  = 3'd6
    } state_e;

    // Kept as plain vectors so the unused code 7 is representable and recoverable.
    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;

    logic       pdb_q, gate_q, ack_q, ready_q, fault_q;
    logic [1:0] ena_q;

    logic       up_d;

    // Next-state, dwell counter and latched testbus select.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (state_q == StOff) begin
            if (enable && supply_ok) begin
                state_d = StBias;
                cnt_d   = cfg_bias_wait;
            end
        end else if (state_q > StFault) begin
            state_d = StOff;
        end else if (!enable) begin
            state_d = StOff;
        end else if (!supply_ok) begin
            state_d = StFault;
        end else begin
            case (state_q)
                StBias: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d = iref_ok ? StPwrup : StFault;
                    end
                end
                StPwrup: begin
                    state_d = StSettle;
                    cnt_d   = cfg_settle;
                end
                StSettle: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (atb_req) begin
                        state_d = StAtb;
                        sel_d   = atb_sel;
                    end
                end
                StAtb: begin
                    if (!atb_req) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    // FAULT is left only through enable=0, handled above.
                    state_d = state_q;
                end
            endcase
        end
    end

    // Distribution is powered in PWRUP, SETTLE, RUN and ATB.
    always_comb begin
        up_d = (state_d == StPwrup) || (state_d == StSettle) ||
               (state_d == StRun)   || (state_d == StAtb);
    end

    // State and registered output decode, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= StOff;
            cnt_q   <= 8'd0;
            sel_q   <= 2'b00;
            pdb_q   <= 1'b0;
            gate_q  <= 1'b0;
            ena_q   <= 2'b00;
            ack_q   <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pdb_q   <= up_d;
            // Gate only opens in states that also assert pdb.
            gate_q  <= (state_d == StRun) || (state_d == StAtb);
            ena_q   <= (state_d == StAtb) ? sel_d : 2'b00;
            ack_q   <= (state_d == StAtb);
            ready_q <= (state_d == StRun) || (state_d == StAtb);
            fault_q <= (state_d == StFault);
        end
    end

    assign pdb         = pdb_q;
    assign clk_gate_en = gate_q;
    assign atb_ena     = ena_q;
    assign atb_ack     = ack_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign state       = state_q;

endmodule
